// File: rtl/uart_rx_stream_adapter.sv
// Pops 12-bit rx FIFO entries, splits them into data byte and error flags, streams
// bytes on a valid/ready interface and keeps saturating per-class error counters.
module uart_rx_stream_adapter #(
   parameter int DATA_WIDTH  = 8,
   parameter int CNT_WIDTH   = 16,
   parameter bit DROP_ERRORS = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [11:0]           fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [2:0]            m_err,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  par_err_cnt,
   output logic [CNT_WIDTH-1:0]  frm_err_cnt,
   output logic [CNT_WIDTH-1:0]  brk_cnt,
   input  logic                  cnt_clear
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EVAL, S_OUT} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [7:0]            r_byte;
   logic [2:0]            r_flags;
   logic [DATA_WIDTH-1:0] r_m_data;
   logic [2:0]            r_m_err;
   logic [CNT_WIDTH-1:0]  r_par_cnt;
   logic [CNT_WIDTH-1:0]  r_frm_cnt;
   logic [CNT_WIDTH-1:0]  r_brk_cnt;
   logic                  w_rd_en;
   logic                  w_err;
   logic                  w_drop;
   logic                  w_hs;
   logic                  w_unused_rsvd;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   assign w_err         = |r_flags;
   assign w_drop        = w_err && DROP_ERRORS;
   assign w_hs          = (r_state == S_OUT) && m_ready;
   assign w_unused_rsvd = fifo_rd_data[11];

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      w_next  = r_state;
      w_rd_en = 1'b0;
      case (r_state)
         S_IDLE:  if (!fifo_empty) begin
                     w_rd_en = 1'b1;
                     w_next  = S_FETCH;
                  end
         S_FETCH: w_next = S_EVAL;
         S_EVAL:  w_next = w_drop ? S_IDLE : S_OUT;
         S_OUT:   if (w_hs) begin
                     if (!fifo_empty) begin
                        w_rd_en = 1'b1;
                        w_next  = S_FETCH;
                     end else begin
                        w_next = S_IDLE;
                     end
                  end
         default: w_next = S_IDLE;
      endcase
   end

   // Pop strobe is combinational from the state; gate it so reset holds it low.
   assign fifo_rd_en = w_rd_en & rst_n;

   // NOTE: sequential state uses non-blocking assignments only; the async reset clears
   // every register here (there is no memory array that would need to stay unreset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_byte   <= '0;
         r_flags  <= '0;
         r_m_data <= '0;
         r_m_err  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH) begin
            r_byte  <= fifo_rd_data[7:0];
            r_flags <= fifo_rd_data[10:8];
         end
         if (r_state == S_EVAL && !w_drop) begin
            r_m_data <= DATA_WIDTH'(r_byte);
            r_m_err  <= DROP_ERRORS ? 3'b000 : r_flags;
         end
      end
   end

   // Clear wins over a same-cycle increment; counters saturate rather than wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par_cnt <= '0;
         r_frm_cnt <= '0;
         r_brk_cnt <= '0;
      end else if (cnt_clear) begin
         r_par_cnt <= '0;
         r_frm_cnt <= '0;
         r_brk_cnt <= '0;
      end else if (r_state == S_EVAL) begin
         if (r_flags[0]) r_par_cnt <= sat_inc(r_par_cnt);
         if (r_flags[1]) r_frm_cnt <= sat_inc(r_frm_cnt);
         if (r_flags[2]) r_brk_cnt <= sat_inc(r_brk_cnt);
      end
   end

   assign m_valid     = (r_state == S_OUT);
   assign m_data      = r_m_data;
   assign m_err       = r_m_err;
   assign par_err_cnt = r_par_cnt;
   assign frm_err_cnt = r_frm_cnt;
   assign brk_cnt     = r_brk_cnt;

endmodule

// File: tb/tb_uart_rx_stream_adapter.sv
// Directed bench: three adapters (drop/16-bit, forward/16-bit, drop/2-bit counters),
// each fed by a small FIFO model, with hand-computed expectations per scenario.
module tb_uart_rx_stream_adapter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   int cyc = 0;
   int viol = 0;
   int errs_a = 0;

   // Instance A: DROP_ERRORS=1, CNT_WIDTH=16
   logic        fifo_empty_a, fifo_rd_en_a, m_valid_a, m_ready_a = 1'b0, cnt_clear_a = 1'b0;
   logic [11:0] fifo_rd_data_a = '0;
   logic [7:0]  m_data_a;
   logic [2:0]  m_err_a;
   logic [15:0] par_a, frm_a, brk_a;
   // Instance B: DROP_ERRORS=0, CNT_WIDTH=16
   logic        fifo_empty_b, fifo_rd_en_b, m_valid_b, m_ready_b = 1'b1, cnt_clear_b = 1'b0;
   logic [11:0] fifo_rd_data_b = '0;
   logic [7:0]  m_data_b;
   logic [2:0]  m_err_b;
   logic [15:0] par_b, frm_b, brk_b;
   // Instance C: DROP_ERRORS=1, CNT_WIDTH=2
   logic        fifo_empty_c, fifo_rd_en_c, m_valid_c, m_ready_c = 1'b1, cnt_clear_c = 1'b0;
   logic [11:0] fifo_rd_data_c = '0;
   logic [7:0]  m_data_c;
   logic [2:0]  m_err_c;
   logic [1:0]  par_c, frm_c, brk_c;

   uart_rx_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16), .DROP_ERRORS(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_a), .fifo_rd_data(fifo_rd_data_a),
      .fifo_rd_en(fifo_rd_en_a), .m_data(m_data_a), .m_err(m_err_a), .m_valid(m_valid_a),
      .m_ready(m_ready_a), .par_err_cnt(par_a), .frm_err_cnt(frm_a), .brk_cnt(brk_a),
      .cnt_clear(cnt_clear_a));

   uart_rx_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16), .DROP_ERRORS(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_b), .fifo_rd_data(fifo_rd_data_b),
      .fifo_rd_en(fifo_rd_en_b), .m_data(m_data_b), .m_err(m_err_b), .m_valid(m_valid_b),
      .m_ready(m_ready_b), .par_err_cnt(par_b), .frm_err_cnt(frm_b), .brk_cnt(brk_b),
      .cnt_clear(cnt_clear_b));

   uart_rx_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(2), .DROP_ERRORS(1'b1)) dut_c (
      .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_c), .fifo_rd_data(fifo_rd_data_c),
      .fifo_rd_en(fifo_rd_en_c), .m_data(m_data_c), .m_err(m_err_c), .m_valid(m_valid_c),
      .m_ready(m_ready_c), .par_err_cnt(par_c), .frm_err_cnt(frm_c), .brk_cnt(brk_c),
      .cnt_clear(cnt_clear_c));

   // FIFO models: one-cycle read latency, pointers as plain counters
   logic [11:0] mem_a [64];
   logic [11:0] mem_b [64];
   logic [11:0] mem_c [64];
   int wp_a = 0, rp_a = 0, pops_a = 0;
   int wp_b = 0, rp_b = 0;
   int wp_c = 0, rp_c = 0;
   assign fifo_empty_a = (wp_a == rp_a);
   assign fifo_empty_b = (wp_b == rp_b);
   assign fifo_empty_c = (wp_c == rp_c);

   logic [7:0] rxd_a[$];
   int         rxt_a[$];
   logic [7:0] rxd_b[$];
   logic [2:0] rxe_b[$];
   int         n_c = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en_a) begin
         fifo_rd_data_a <= mem_a[rp_a % 64];
         rp_a <= rp_a + 1;
         pops_a <= pops_a + 1;
      end
      if (fifo_rd_en_b) begin
         fifo_rd_data_b <= mem_b[rp_b % 64];
         rp_b <= rp_b + 1;
      end
      if (fifo_rd_en_c) begin
         fifo_rd_data_c <= mem_c[rp_c % 64];
         rp_c <= rp_c + 1;
      end
      if ((fifo_rd_en_a && fifo_empty_a) || (fifo_rd_en_b && fifo_empty_b) ||
          (fifo_rd_en_c && fifo_empty_c))
         viol <= viol + 1;
      if (m_valid_a && m_ready_a) begin
         rxd_a.push_back(m_data_a);
         rxt_a.push_back(cyc);
         if (m_err_a != 3'b000) errs_a <= errs_a + 1;
      end
      if (m_valid_b && m_ready_b) begin
         rxd_b.push_back(m_data_b);
         rxe_b.push_back(m_err_b);
      end
      if (m_valid_c && m_ready_c) n_c <= n_c + 1;
   end

   task automatic push(input int inst, input logic [11:0] e);
      case (inst)
         0:       begin mem_a[wp_a % 64] = e; wp_a++; end
         1:       begin mem_b[wp_b % 64] = e; wp_b++; end
         default: begin mem_c[wp_c % 64] = e; wp_c++; end
      endcase
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      wait_cycles(2);
      push(0, 12'h041);
      #1;
      nvec++; if (fifo_rd_en_a !== 1'b0) begin nerr++; $display("FAIL reset_rd_en: got %b exp 0", fifo_rd_en_a); end
      nvec++; if (m_valid_a !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b exp 0", m_valid_a); end
      nvec++; if (m_data_a !== 8'h00 || m_err_a !== 3'b000) begin nerr++; $display("FAIL reset_data: got %h/%b exp 00/000", m_data_a, m_err_a); end
      nvec++; if (par_a !== 16'd0 || frm_a !== 16'd0 || brk_a !== 16'd0) begin nerr++; $display("FAIL reset_cnt: got %0d/%0d/%0d exp 0/0/0", par_a, frm_a, brk_a); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      bit held = 1'b1;
      wait_cycles(3);
      nvec++; if (m_valid_a !== 1'b1) begin nerr++; $display("FAIL single_valid: got %b exp 1", m_valid_a); end
      nvec++; if (m_data_a !== 8'h41 || m_err_a !== 3'b000) begin nerr++; $display("FAIL single_data: got %h/%b exp 41/000", m_data_a, m_err_a); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (m_valid_a !== 1'b1 || m_data_a !== 8'h41) held = 1'b0;
      end
      nvec++; if (held !== 1'b1 || pops_a !== 1) begin nerr++; $display("FAIL single_hold: held %b pops %0d exp 1/1", held, pops_a); end
      m_ready_a = 1'b1;
      @(negedge clk);
      nvec++; if (m_valid_a !== 1'b0) begin nerr++; $display("FAIL single_drop_valid: got %b exp 0", m_valid_a); end
      nvec++; if (rxd_a.size() != 1 || rxd_a[0] !== 8'h41) begin nerr++; $display("FAIL single_rx: size %0d byte %h exp 1/41", rxd_a.size(), rxd_a[0]); end
   endtask

   task automatic test_drop;
      push(0, 12'h1AA);
      push(0, 12'h055);
      wait_cycles(12);
      nvec++; if (rxd_a.size() != 2 || rxd_a[1] !== 8'h55) begin nerr++; $display("FAIL drop_rx: size %0d byte %h exp 2/55", rxd_a.size(), rxd_a[1]); end
      nvec++; if (par_a !== 16'd1 || frm_a !== 16'd0 || brk_a !== 16'd0) begin nerr++; $display("FAIL drop_cnt: got %0d/%0d/%0d exp 1/0/0", par_a, frm_a, brk_a); end
      nvec++; if (errs_a !== 0) begin nerr++; $display("FAIL drop_merr: got %0d flagged bytes exp 0", errs_a); end
   endtask

   task automatic test_forward;
      push(1, 12'h600);
      wait_cycles(8);
      nvec++; if (rxd_b.size() != 1 || rxd_b[0] !== 8'h00 || rxe_b[0] !== 3'b110) begin nerr++; $display("FAIL fwd_600: size %0d byte %h err %b exp 1/00/110", rxd_b.size(), rxd_b[0], rxe_b[0]); end
      nvec++; if (par_b !== 16'd0 || frm_b !== 16'd1 || brk_b !== 16'd1) begin nerr++; $display("FAIL fwd_cnt1: got %0d/%0d/%0d exp 0/1/1", par_b, frm_b, brk_b); end
      push(1, 12'h700);
      push(1, 12'h855);
      wait_cycles(12);
      nvec++; if (rxd_b.size() != 3 || rxe_b[1] !== 3'b111) begin nerr++; $display("FAIL fwd_700: size %0d err %b exp 3/111", rxd_b.size(), rxe_b[1]); end
      nvec++; if (rxd_b[2] !== 8'h55 || rxe_b[2] !== 3'b000) begin nerr++; $display("FAIL fwd_rsvd: byte %h err %b exp 55/000", rxd_b[2], rxe_b[2]); end
      nvec++; if (par_b !== 16'd1 || frm_b !== 16'd2 || brk_b !== 16'd2) begin nerr++; $display("FAIL fwd_cnt2: got %0d/%0d/%0d exp 1/2/2", par_b, frm_b, brk_b); end
   endtask

   task automatic test_stall;
      int  p0;
      bit  stable = 1'b1;
      bit  seen = 1'b0;
      m_ready_a = 1'b0;
      @(negedge clk);
      p0 = pops_a;
      push(0, 12'h011);
      push(0, 12'h022);
      push(0, 12'h033);
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         if (m_valid_a) begin
            seen = 1'b1;
            if (m_data_a !== 8'h11) stable = 1'b0;
         end else if (seen) begin
            stable = 1'b0;
         end
      end
      nvec++; if (m_valid_a !== 1'b1 || stable !== 1'b1) begin nerr++; $display("FAIL stall_hold: valid %b stable %b exp 1/1", m_valid_a, stable); end
      nvec++; if (pops_a - p0 != 1) begin nerr++; $display("FAIL stall_pops: got %0d exp 1", pops_a - p0); end
      m_ready_a = 1'b1;
      wait_cycles(15);
      nvec++; if (rxd_a.size() != 5 || rxd_a[2] !== 8'h11 || rxd_a[3] !== 8'h22 || rxd_a[4] !== 8'h33) begin
         nerr++; $display("FAIL stall_order: size %0d bytes %h %h %h exp 5 11 22 33", rxd_a.size(), rxd_a[2], rxd_a[3], rxd_a[4]);
      end
      nvec++; if (pops_a - p0 != 3) begin nerr++; $display("FAIL stall_pops_end: got %0d exp 3", pops_a - p0); end
   endtask

   task automatic test_back_to_back;
      for (int i = 1; i <= 4; i++) push(0, 12'h0A0 + 12'(i));
      wait_cycles(20);
      nvec++; if (rxd_a.size() != 9 || rxd_a[8] !== 8'hA4) begin nerr++; $display("FAIL b2b_rx: size %0d last %h exp 9/a4", rxd_a.size(), rxd_a[8]); end
      for (int k = 6; k <= 8; k++) begin
         nvec++; if (rxt_a[k] - rxt_a[k-1] != 3) begin nerr++; $display("FAIL b2b_gap%0d: got %0d exp 3", k, rxt_a[k] - rxt_a[k-1]); end
      end
   endtask

   task automatic test_saturate;
      push(2, 12'h101);
      push(2, 12'h102);
      wait_cycles(10);
      nvec++; if (par_c !== 2'd2) begin nerr++; $display("FAIL sat_two: got %0d exp 2", par_c); end
      for (int i = 0; i < 3; i++) push(2, 12'h110 + 12'(i));
      wait_cycles(14);
      nvec++; if (par_c !== 2'd3 || frm_c !== 2'd0 || brk_c !== 2'd0) begin nerr++; $display("FAIL sat_five: got %0d/%0d/%0d exp 3/0/0", par_c, frm_c, brk_c); end
      nvec++; if (n_c !== 0) begin nerr++; $display("FAIL sat_dropped: got %0d outputs exp 0", n_c); end
      push(2, 12'h100);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      cnt_clear_c = 1'b1;
      @(negedge clk);
      cnt_clear_c = 1'b0;
      nvec++; if (par_c !== 2'd0) begin nerr++; $display("FAIL clear_prio: got %0d exp 0", par_c); end
      push(2, 12'h100);
      wait_cycles(6);
      nvec++; if (par_c !== 2'd1) begin nerr++; $display("FAIL clear_recount: got %0d exp 1", par_c); end
   endtask

   task automatic test_reset_mid;
      m_ready_a = 1'b0;
      push(0, 12'h0AB);
      wait_cycles(6);
      nvec++; if (m_valid_a !== 1'b1 || m_data_a !== 8'hAB) begin nerr++; $display("FAIL mid_pre: valid %b data %h exp 1/ab", m_valid_a, m_data_a); end
      #2;
      rst_n = 1'b0;
      #1;
      nvec++; if (m_valid_a !== 1'b0) begin nerr++; $display("FAIL mid_valid: got %b exp 0", m_valid_a); end
      nvec++; if (par_a !== 16'd0 || frm_b !== 16'd0 || brk_b !== 16'd0 || par_c !== 2'd0) begin
         nerr++; $display("FAIL mid_cnt: got %0d/%0d/%0d/%0d exp 0/0/0/0", par_a, frm_b, brk_b, par_c);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_ready_a = 1'b1;
      wait_cycles(6);
      nvec++; if (rxd_a.size() != 9 || m_valid_a !== 1'b0) begin nerr++; $display("FAIL mid_lost: size %0d valid %b exp 9/0", rxd_a.size(), m_valid_a); end
      push(0, 12'h0CD);
      wait_cycles(8);
      nvec++; if (rxd_a.size() != 10 || rxd_a[9] !== 8'hCD) begin nerr++; $display("FAIL mid_resume: size %0d last %h exp 10/cd", rxd_a.size(), rxd_a[9]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_drop();
      test_forward();
      test_stall();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      nvec++; if (viol !== 0) begin nerr++; $display("FAIL rd_en_while_empty: got %0d exp 0", viol); end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
